// File: rtl/running_max_pkg.sv
// Shared types and constants for the running-max stage.
// Score/difference format, V vector type and row FSM states.
package running_max_pkg;

    localparam int MAX_EMBEDDING_DIM = 4;
    localparam int INTEGER_WIDTH     = 8;

    localparam int EXPMUL_DIFF_IN_W = 8;
    localparam int EXPMUL_DIFF_IN_F = 4;

    localparam int RUNMAX_ROW_LEN = MAX_EMBEDDING_DIM;

    typedef logic signed [EXPMUL_DIFF_IN_W-1:0] EXPMUL_DIFF_IN_QT;

    typedef logic [MAX_EMBEDDING_DIM-1:0][INTEGER_WIDTH-1:0] V_VECTOR_T;

    typedef enum logic {
        IDLE = 1'b0,
        ROW  = 1'b1
    } RUNMAX_STATE_E;

endpackage

// File: rtl/sat_sub_nonpos.sv
// Signed a - b, clamped to [-2^(W-1), 0].
// Positive results cannot occur upstream; they clamp to 0 anyway.
module sat_sub_nonpos #(
    parameter int W = 8
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] y
);

    logic signed [W:0] d;

    // One extra bit so the raw difference never wraps.
    // In range negatives have the top two bits both set.
    always_comb begin
        d = {a[W-1], a} - {b[W-1], b};
        if (!d[W]) begin
            y = '0;
        end else if (!d[W-1]) begin
            y = {1'b1, {(W-1){1'b0}}};
        end else begin
            y = d[W-1:0];
        end
    end

endmodule

// File: rtl/running_max.sv
// Online-softmax front end: running row max plus the two
// non-positive exponent arguments, one register stage deep.
module running_max
    import running_max_pkg::*;
#(
    parameter int SCORE_W = EXPMUL_DIFF_IN_W,
    parameter int DIM     = MAX_EMBEDDING_DIM,
    parameter int ELEM_W  = INTEGER_WIDTH,
    parameter int ROW_LEN = RUNMAX_ROW_LEN
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          vld_in,
    output logic                          rdy_out,
    input  logic signed [SCORE_W-1:0]     s_in,
    input  logic [DIM-1:0][ELEM_W-1:0]    v_in,
    output logic                          vld_out,
    input  logic                          rdy_in,
    output logic signed [SCORE_W-1:0]     diff_s_out,
    output logic signed [SCORE_W-1:0]     diff_m_out,
    output logic                          first_out,
    output logic                          last_out,
    output logic [DIM-1:0][ELEM_W-1:0]    v_out,
    output RUNMAX_STATE_E                 state_out
);

    localparam int IDX_W = $clog2(ROW_LEN);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(ROW_LEN - 1);
    localparam logic signed [SCORE_W-1:0] S_MIN =
        {1'b1, {(SCORE_W-1){1'b0}}};

    logic                       vld_q, vld_d;
    logic signed [SCORE_W-1:0]  ds_q, ds_d;
    logic signed [SCORE_W-1:0]  dm_q, dm_d;
    logic                       first_q, first_d;
    logic                       last_q, last_d;
    logic [DIM-1:0][ELEM_W-1:0] v_q, v_d;
    logic signed [SCORE_W-1:0]  m_q, m_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    RUNMAX_STATE_E              state_q, state_d;

    logic                       xfer;
    logic                       row_start;
    logic                       is_last;
    logic signed [SCORE_W-1:0]  m_new;
    logic signed [SCORE_W-1:0]  ds_raw;
    logic signed [SCORE_W-1:0]  dm_raw;
    logic signed [SCORE_W-1:0]  ds_new;
    logic signed [SCORE_W-1:0]  dm_new;

    assign rdy_out = !vld_q || rdy_in;
    assign xfer    = vld_in && rdy_out;

    sat_sub_nonpos #(.W(SCORE_W)) u_sub_s (
        .a (s_in),
        .b (m_new),
        .y (ds_raw)
    );

    sat_sub_nonpos #(.W(SCORE_W)) u_sub_m (
        .a (m_q),
        .b (m_new),
        .y (dm_raw)
    );

    // New max and exponent arguments; a row start ignores the old max.
    always_comb begin
        row_start = (idx_q == '0);
        is_last   = (idx_q == IDX_LAST);
        if (row_start) begin
            m_new = s_in;
        end else if (s_in > m_q) begin
            m_new = s_in;
        end else begin
            m_new = m_q;
        end
        ds_new = row_start ? '0 : ds_raw;
        dm_new = row_start ? S_MIN : dm_raw;
    end

    // Output register load/drain, row counter and row FSM.
    always_comb begin
        vld_d   = vld_q;
        ds_d    = ds_q;
        dm_d    = dm_q;
        first_d = first_q;
        last_d  = last_q;
        v_d     = v_q;
        m_d     = m_q;
        idx_d   = idx_q;
        state_d = state_q;

        if (xfer) begin
            vld_d   = 1'b1;
            ds_d    = ds_new;
            dm_d    = dm_new;
            first_d = row_start;
            last_d  = is_last;
            v_d     = v_in;
            m_d     = m_new;
            idx_d   = is_last ? '0 : idx_q + IDX_W'(1);
        end else if (vld_q && rdy_in) begin
            vld_d = 1'b0;
        end

        unique case (state_q)
            IDLE: if (xfer) state_d = ROW;
            ROW:  if (xfer && is_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_q   <= 1'b0;
            ds_q    <= '0;
            dm_q    <= '0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            v_q     <= '0;
            m_q     <= S_MIN;
            idx_q   <= '0;
            state_q <= IDLE;
        end else begin
            vld_q   <= vld_d;
            ds_q    <= ds_d;
            dm_q    <= dm_d;
            first_q <= first_d;
            last_q  <= last_d;
            v_q     <= v_d;
            m_q     <= m_d;
            idx_q   <= idx_d;
            state_q <= state_d;
        end
    end

    assign vld_out    = vld_q;
    assign diff_s_out = ds_q;
    assign diff_m_out = dm_q;
    assign first_out  = first_q;
    assign last_out   = last_q;
    assign v_out      = v_q;
    assign state_out  = state_q;

endmodule

// File: tb/tb_running_max.sv
// Directed and randomized bench for running_max.
// Each scenario task does its own inline comparisons.
module tb_running_max;
    import running_max_pkg::*;

    localparam int SW = EXPMUL_DIFF_IN_W;

    typedef struct {
        logic signed [SW-1:0] ds;
        logic signed [SW-1:0] dm;
        logic                 first;
        logic                 last;
        V_VECTOR_T            v;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 vld_in = 1'b0;
    logic                 rdy_out;
    logic signed [SW-1:0] s_in = '0;
    V_VECTOR_T            v_in = '0;
    logic                 vld_out;
    logic                 rdy_in = 1'b1;
    logic signed [SW-1:0] diff_s_out;
    logic signed [SW-1:0] diff_m_out;
    logic                 first_out;
    logic                 last_out;
    V_VECTOR_T            v_out;
    RUNMAX_STATE_E        state_out;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    running_max dut (
        .clk        (clk),
        .rst        (rst),
        .vld_in     (vld_in),
        .rdy_out    (rdy_out),
        .s_in       (s_in),
        .v_in       (v_in),
        .vld_out    (vld_out),
        .rdy_in     (rdy_in),
        .diff_s_out (diff_s_out),
        .diff_m_out (diff_m_out),
        .first_out  (first_out),
        .last_out   (last_out),
        .v_out      (v_out),
        .state_out  (state_out)
    );

    function automatic V_VECTOR_T mkv(input int base);
        V_VECTOR_T v;
        for (int k = 0; k < MAX_EMBEDDING_DIM; k++) begin
            v[k] = INTEGER_WIDTH'(base * 4 + k + 1);
        end
        return v;
    endfunction

    function automatic int sat_np(input int x);
        if (x > 0) return 0;
        if (x < -128) return -128;
        return x;
    endfunction

    task automatic apply_reset();
        rst    = 1'b0;
        vld_in = 1'b0;
        rdy_in = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        vld_in = 1'b1;
        s_in   = 8'sd55;
        v_in   = mkv(7);
        rst    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (vld_out !== 1'b0 || diff_s_out !== 8'sd0 || diff_m_out !== 8'sd0
            || first_out !== 1'b0 || last_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outs got vld=%b ds=%0d dm=%0d f=%b l=%b want 0 0 0 0 0",
                     vld_out, diff_s_out, diff_m_out, first_out, last_out);
        end
        n_checks++;
        if (v_out !== '0) begin
            n_fail++;
            $display("FAIL reset_v got %h want 0", v_out);
        end
        n_checks++;
        if (rdy_out !== 1'b1 || state_out !== IDLE) begin
            n_fail++;
            $display("FAIL reset_rdy_state got rdy=%b st=%0d want 1 0",
                     rdy_out, state_out);
        end
        vld_in = 1'b0;
        rst    = 1'b1;
    endtask

    task automatic test_basic_row();
        logic signed [SW-1:0] sc[4]  = '{10, 20, 5, 30};
        logic signed [SW-1:0] eds[4] = '{0, 0, -15, 0};
        logic signed [SW-1:0] edm[4] = '{-128, -10, 0, -10};
        logic                 ef[4]  = '{1, 0, 0, 0};
        logic                 el[4]  = '{0, 0, 0, 1};
        rdy_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            vld_in = 1'b1;
            s_in   = sc[i];
            v_in   = mkv(i);
            @(posedge clk);
            #1;
            n_checks++;
            if (vld_out !== 1'b1 || diff_s_out !== eds[i] || diff_m_out !== edm[i]
                || first_out !== ef[i] || last_out !== el[i] || v_out !== mkv(i)) begin
                n_fail++;
                $display("FAIL basic[%0d] got vld=%b ds=%0d dm=%0d f=%b l=%b want 1 %0d %0d %b %b",
                         i, vld_out, diff_s_out, diff_m_out, first_out, last_out,
                         eds[i], edm[i], ef[i], el[i]);
            end
            if (i == 0) begin
                n_checks++;
                if (state_out !== ROW) begin
                    n_fail++;
                    $display("FAIL basic_state_row got %0d want %0d", state_out, ROW);
                end
            end
        end
        vld_in = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (vld_out !== 1'b0 || state_out !== IDLE) begin
            n_fail++;
            $display("FAIL basic_drain got vld=%b st=%0d want 0 0", vld_out, state_out);
        end
    endtask

    task automatic test_saturation();
        logic signed [SW-1:0] sc[4]  = '{-128, 127, -128, 0};
        logic signed [SW-1:0] eds[4] = '{0, 0, -128, -127};
        logic signed [SW-1:0] edm[4] = '{-128, -128, 0, 0};
        for (int i = 0; i < 4; i++) begin
            vld_in = 1'b1;
            s_in   = sc[i];
            v_in   = mkv(20 + i);
            @(posedge clk);
            #1;
            n_checks++;
            if (diff_s_out !== eds[i] || diff_m_out !== edm[i]
                || first_out !== (i == 0) || last_out !== (i == 3)) begin
                n_fail++;
                $display("FAIL sat[%0d] got ds=%0d dm=%0d f=%b l=%b want %0d %0d",
                         i, diff_s_out, diff_m_out, first_out, last_out,
                         eds[i], edm[i]);
            end
        end
        vld_in = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        logic signed [SW-1:0] sc[4] = '{40, 60, 50, 70};
        exp_t ex[4];
        logic [49:0] snap = '0;
        logic held = 1'b0;
        int sent = 0;
        int got  = 0;
        ex[0] = '{ds: 0,   dm: -128, first: 1, last: 0, v: mkv(10)};
        ex[1] = '{ds: 0,   dm: -20,  first: 0, last: 0, v: mkv(11)};
        ex[2] = '{ds: -10, dm: 0,    first: 0, last: 0, v: mkv(12)};
        ex[3] = '{ds: 0,   dm: -10,  first: 0, last: 1, v: mkv(13)};
        vld_in = 1'b1;
        s_in   = sc[0];
        v_in   = mkv(10);
        for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
            rdy_in = !(cyc >= 1 && cyc <= 3);
            @(negedge clk);
            if (vld_out && !rdy_in) begin
                n_checks++;
                if (rdy_out !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bp_rdy_out cyc=%0d got %b want 0", cyc, rdy_out);
                end
                if (held) begin
                    n_checks++;
                    if ({diff_s_out, diff_m_out, first_out, last_out, v_out} !== snap) begin
                        n_fail++;
                        $display("FAIL bp_hold cyc=%0d got %h want %h", cyc,
                                 {diff_s_out, diff_m_out, first_out, last_out, v_out},
                                 snap);
                    end
                end
                snap = {diff_s_out, diff_m_out, first_out, last_out, v_out};
                held = 1'b1;
            end else begin
                held = 1'b0;
            end
            if (vld_out && rdy_in) begin
                n_checks++;
                if (diff_s_out !== ex[got].ds || diff_m_out !== ex[got].dm
                    || first_out !== ex[got].first || last_out !== ex[got].last
                    || v_out !== ex[got].v) begin
                    n_fail++;
                    $display("FAIL bp_out[%0d] got ds=%0d dm=%0d f=%b l=%b want %0d %0d %b %b",
                             got, diff_s_out, diff_m_out, first_out, last_out,
                             ex[got].ds, ex[got].dm, ex[got].first, ex[got].last);
                end
                got++;
            end
            if (vld_in && rdy_out) sent++;
            @(posedge clk);
            #1;
            if (sent < 4) begin
                s_in = sc[sent];
                v_in = mkv(10 + sent);
            end else begin
                vld_in = 1'b0;
            end
        end
        n_checks++;
        if (got != 4 || sent != 4) begin
            n_fail++;
            $display("FAIL bp_count got out=%0d in=%0d want 4 4", got, sent);
        end
        rdy_in = 1'b1;
        vld_in = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        logic signed [SW-1:0] sc[8]  = '{0, 100, 20, 30, -50, -50, -50, -50};
        logic signed [SW-1:0] eds[8] = '{0, 0, -80, -70, 0, 0, 0, 0};
        logic signed [SW-1:0] edm[8] = '{-128, -100, 0, 0, -128, 0, 0, 0};
        rdy_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            vld_in = 1'b1;
            s_in   = sc[i];
            v_in   = mkv(30 + i);
            @(posedge clk);
            #1;
            n_checks++;
            if (vld_out !== 1'b1 || diff_s_out !== eds[i] || diff_m_out !== edm[i]
                || first_out !== (i % 4 == 0) || last_out !== (i % 4 == 3)
                || v_out !== mkv(30 + i)) begin
                n_fail++;
                $display("FAIL b2b[%0d] got vld=%b ds=%0d dm=%0d f=%b l=%b want 1 %0d %0d",
                         i, vld_out, diff_s_out, diff_m_out, first_out, last_out,
                         eds[i], edm[i]);
            end
        end
        vld_in = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_row();
        rdy_in = 1'b1;
        for (int i = 0; i < 2; i++) begin
            vld_in = 1'b1;
            s_in   = SW'(5 + i);
            v_in   = mkv(40 + i);
            @(posedge clk);
            #1;
        end
        vld_in = 1'b0;
        rst    = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (vld_out !== 1'b0 || diff_s_out !== 8'sd0 || diff_m_out !== 8'sd0
            || first_out !== 1'b0 || last_out !== 1'b0 || v_out !== '0) begin
            n_fail++;
            $display("FAIL midrst_outs got vld=%b ds=%0d dm=%0d f=%b l=%b want all 0",
                     vld_out, diff_s_out, diff_m_out, first_out, last_out);
        end
        n_checks++;
        if (state_out !== IDLE || rdy_out !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_state got st=%0d rdy=%b want 0 1", state_out, rdy_out);
        end
        rst    = 1'b1;
        vld_in = 1'b1;
        s_in   = 8'sd9;
        v_in   = mkv(45);
        @(posedge clk);
        #1;
        n_checks++;
        if (vld_out !== 1'b1 || first_out !== 1'b1 || diff_s_out !== 8'sd0
            || diff_m_out !== -8'sd128 || last_out !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_first got vld=%b f=%b ds=%0d dm=%0d l=%b want 1 1 0 -128 0",
                     vld_out, first_out, diff_s_out, diff_m_out, last_out);
        end
        vld_in = 1'b0;
    endtask

    task automatic test_random();
        exp_t q[$];
        exp_t e;
        int acc  = 0;
        int mm   = -128;
        int midx = 0;
        int mn;
        int s;
        apply_reset();
        for (int cyc = 0; cyc < 6000 && (acc < 1000 || q.size() > 0); cyc++) begin
            vld_in = (acc < 1000) && ($urandom_range(0, 9) < 7);
            rdy_in = ($urandom_range(0, 9) < 7);
            s_in   = SW'($urandom);
            v_in   = V_VECTOR_T'($urandom);
            @(negedge clk);
            if (vld_out && rdy_in) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rand_extra cyc=%0d got unexpected output want none", cyc);
                end else begin
                    e = q.pop_front();
                    if (diff_s_out !== e.ds || diff_m_out !== e.dm
                        || first_out !== e.first || last_out !== e.last
                        || v_out !== e.v) begin
                        n_fail++;
                        $display("FAIL rand cyc=%0d got ds=%0d dm=%0d f=%b l=%b v=%h want %0d %0d %b %b %h",
                                 cyc, diff_s_out, diff_m_out, first_out, last_out, v_out,
                                 e.ds, e.dm, e.first, e.last, e.v);
                    end
                end
            end
            if (vld_in && rdy_out) begin
                s = int'(s_in);
                if (midx == 0) begin
                    mn = s;
                    e.ds = '0;
                    e.dm = -8'sd128;
                end else begin
                    mn = (s > mm) ? s : mm;
                    e.ds = SW'(sat_np(s - mn));
                    e.dm = SW'(sat_np(mm - mn));
                end
                e.first = (midx == 0);
                e.last  = (midx == RUNMAX_ROW_LEN - 1);
                e.v     = v_in;
                q.push_back(e);
                mm   = mn;
                midx = (midx == RUNMAX_ROW_LEN - 1) ? 0 : midx + 1;
                acc++;
            end
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (acc != 1000 || q.size() != 0) begin
            n_fail++;
            $display("FAIL rand_count got acc=%0d pending=%0d want 1000 0", acc, q.size());
        end
        vld_in = 1'b0;
        rdy_in = 1'b1;
    endtask

    initial begin
        apply_reset();
        test_reset();
        test_basic_row();
        test_saturation();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_row();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
